stream_bcjr_max_product_core: RTL and testbench

// Streaming max-log (max-product) BCJR SISO decoder for one constituent code of the turbo decoder.
// - Input: one trellis step per beat; each beat carries BITS_PER_SYMBOL IEEE-754 single-precision channel LLRs.
// - After a full SYMBOLS-step frame, runs the forward/backward recursions.
// - Output: per-coded-bit a-posteriori LLRs, streamed in symbol order.
// - Must be bit-exact to the team's behavioural BCJR model (bcjr_max_product_behav) for the same trellis.

---
 rtl/stream_bcjr_max_product_core.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_stream_bcjr_max_product_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_bcjr_max_product_core.sv
// stream_bcjr_max_product_core
// Streaming max-log (max-product) BCJR SISO decoder for one recursive
// systematic constituent code. A frame of SYMBOLS trellis steps is collected.
// The forward recursion then stores alpha_k for every step. The backward
// recursion carries beta and writes the a-posteriori LLRs into an output
// buffer. The buffer is then streamed out in step order.
// All metric arithmetic is IEEE-754 binary32 add/compare with round-to-nearest-even.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; aborts any partial frame
//   in_valid   LLRVector carries one trellis step
//   LLRVector  BITS_PER_SYMBOL float32 channel LLRs, word j at [32*j +: 32]
//   out_valid  LLR_D carries one trellis step (SYMBOLS consecutive beats)
//   LLR_D      BITS_PER_SYMBOL float32 output LLRs, zero while out_valid=0
module stream_bcjr_max_product_core #(
    parameter int    BITS            = 32,
    parameter string PRECISION       = "SINGLE",
    parameter int    BITS_PER_SYMBOL = 2,
    parameter int    SYMBOLS         = 17,
    parameter int    STATES          = 4,
    parameter int    RECURSIVE       = 7,
    parameter int    POLY0           = 5,
    parameter int    POLY1           = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [BITS*BITS_PER_SYMBOL-1:0] LLRVector,
    output logic                            out_valid,
    output logic [BITS*BITS_PER_SYMBOL-1:0] LLR_D
);

    localparam int NO    = BITS_PER_SYMBOL;
    localparam int NCODE = 1 << NO;
    localparam int M     = $clog2(STATES);
    localparam int CW    = $clog2(SYMBOLS);
    localparam int VW    = BITS * NO;
    localparam logic [CW-1:0] LAST    = CW'(SYMBOLS - 1);
    localparam logic [CW-1:0] ZERO    = {CW{1'b0}};
    localparam logic [31:0]   NEG_INF = 32'hFF80_0000;
    localparam logic [M-1:0]  REC_T   = M'(RECURSIVE);
    localparam logic [M:0]    P0_T    = (M + 1)'(POLY0);
    localparam logic [M:0]    P1_T    = (M + 1)'(POLY1);

    if (BITS != 32 || PRECISION != "SINGLE" || SYMBOLS < 2 || STATES < 4) begin : g_cfg_error
        $error("stream_bcjr_max_product_core: unsupported configuration");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FWD  = 3'd2,
        ST_BWD  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // ---------------------------------------------------------------- trellis
    function automatic logic fb_a(input logic [M-1:0] s, input logic u);
        return u ^ (^(REC_T & s));
    endfunction

    function automatic logic [M-1:0] next_state(input logic [M-1:0] s, input logic u);
        return {fb_a(s, u), s[M-1:1]};
    endfunction

    function automatic logic [NO-1:0] code_bits(input logic [M-1:0] s, input logic u);
        logic [NO-1:0] c;
        c = {NO{1'b0}};
        for (int j = 0; j < NO; j++) begin
            c[j] = ^(((j == 0) ? P0_T : P1_T) & {fb_a(s, u), s});
        end
        return c;
    endfunction

    // ---------------------------------------------------------- float32 ops
    // a + b, round-to-nearest-even, subnormals kept, overflow to inf.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        logic [7:0]  ex, ey, d;
        logic [23:0] mx, my;
        logic [57:0] yw;
        logic [26:0] xs, ys, nm;
        logic [27:0] s;
        logic [4:0]  lz, sh;
        logic [24:0] rm;
        logic [8:0]  e;
        logic        found, rup;
        r = 32'h0; x = a; y = b; ex = 8'h0; ey = 8'h0; d = 8'h0; mx = 24'h0; my = 24'h0;
        yw = 58'h0; xs = 27'h0; ys = 27'h0; nm = 27'h0; s = 28'h0; lz = 5'h0; sh = 5'h0;
        rm = 25'h0; e = 9'h0; found = 1'b0; rup = 1'b0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) r = 32'h7FC0_0000;
            else if (a[30:23] == 8'hFF) r = a;
            else r = b;
        end else if (a[30:0] == 31'h0 && b[30:0] == 31'h0) begin
            r = {a[31] & b[31], 31'h0};
        end else if (a[30:0] == 31'h0) begin
            r = b;
        end else if (b[30:0] == 31'h0) begin
            r = a;
        end else begin
            // x is the operand of larger magnitude so the difference is never negative
            if (a[30:0] >= b[30:0]) begin x = a; y = b; end
            else begin x = b; y = a; end
            ex = (x[30:23] == 8'h0) ? 8'd1 : x[30:23];
            ey = (y[30:23] == 8'h0) ? 8'd1 : y[30:23];
            mx = {x[30:23] != 8'h0, x[22:0]};
            my = {y[30:23] != 8'h0, y[22:0]};
            d  = ex - ey;
            // Wide shift keeps every shifted-out bit so the sticky bit is exact
            yw = {my, 34'h0} >> ((d > 8'd34) ? 8'd34 : d);
            ys = {yw[57:32], |yw[31:0]};
            xs = {mx, 3'b000};
            if (x[31] == y[31]) s = {1'b0, xs} + {1'b0, ys};
            else s = {1'b0, xs} - {1'b0, ys};
            if (s == 28'h0) begin
                r = 32'h0;
            end else begin
                if (s[27]) begin
                    nm = {s[27:2], s[1] | s[0]};
                    e  = {1'b0, ex} + 9'd1;
                end else begin
                    for (int i = 26; i >= 0; i--) begin
                        if (!found) begin
                            if (s[i]) found = 1'b1;
                            else lz = lz + 5'd1;
                        end
                    end
                    // Never normalise below the minimum exponent: result goes subnormal
                    if ({3'b000, lz} < ex - 8'd1) sh = lz;
                    else sh = 5'(ex - 8'd1);
                    nm = s[26:0] << sh;
                    e  = {1'b0, ex} - {4'h0, sh};
                end
                rup = nm[2] & (nm[1] | nm[0] | nm[3]);
                rm  = {1'b0, nm[26:3]} + {24'h0, rup};
                if (rm[24]) begin
                    rm = {1'b0, rm[24:1]};
                    e  = e + 9'd1;
                end
                if (e >= 9'd255) r = {x[31], 8'hFF, 23'h0};
                else r = {x[31], rm[23] ? e[7:0] : 8'h0, rm[22:0]};
            end
        end
        return r;
    endfunction

    // a >= b in IEEE order (finite values and infinities; +0 == -0)
    function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[30:0] == 31'h0 && b[30:0] == 31'h0) r = 1'b1;
        else if (a[31] != b[31]) r = b[31];
        else if (!a[31]) r = (a[30:0] >= b[30:0]);
        else r = (a[30:0] <= b[30:0]);
        return r;
    endfunction

    // Ties keep the first operand
    function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
        return fp_ge(a, b) ? a : b;
    endfunction

    // ---------------------------------------------------------------- storage
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [VW-1:0]   llr_mem   [SYMBOLS];
    logic [VW-1:0]   out_mem   [SYMBOLS];
    logic [32*STATES-1:0] alpha_mem [SYMBOLS];
    logic [31:0]     alpha_q   [STATES];
    logic [31:0]     beta_q    [STATES];
    logic            out_valid_q, out_valid_d;
    logic [VW-1:0]   llr_out_q, llr_out_d;

    logic [31:0]     lin_s       [NO];
    logic [31:0]     gam_s       [NCODE];
    logic [31:0]     alpha_k_s   [STATES];
    logic [31:0]     alpha_nxt_s [STATES];
    logic [31:0]     beta_nxt_s  [STATES];
    logic [31:0]     mx0_s       [NO];
    logic [31:0]     mx1_s       [NO];
    logic [VW-1:0]   llr_pk_s;

    // Trellis step: branch metrics, alpha update, beta update and LLRs for step cnt_q
    always_comb begin
        logic [NO-1:0] cv;
        logic [M-1:0]  ns;
        logic [31:0]   g, ag, pm;
        cv = {NO{1'b0}}; ns = {M{1'b0}}; g = 32'h0; ag = 32'h0; pm = 32'h0;
        llr_pk_s = {VW{1'b0}};
        for (int j = 0; j < NO; j++) begin
            lin_s[j] = llr_mem[cnt_q][j*32 +: 32];
            mx0_s[j] = NEG_INF;
            mx1_s[j] = NEG_INF;
        end
        // gamma depends only on the code word, accumulated from +0.0 in bit order
        for (int c = 0; c < NCODE; c++) begin
            cv = NO'(c);
            g  = 32'h0;
            for (int j = 0; j < NO; j++) begin
                g = fp_add(g, cv[j] ? lin_s[j] : 32'h0);
            end
            gam_s[c] = g;
        end
        for (int s = 0; s < STATES; s++) begin
            alpha_k_s[s]   = (state_q == ST_FWD) ? alpha_q[s] : alpha_mem[cnt_q][s*32 +: 32];
            alpha_nxt_s[s] = NEG_INF;
            beta_nxt_s[s]  = NEG_INF;
        end
        for (int s = 0; s < STATES; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns = next_state(M'(s), 1'(u));
                cv = code_bits(M'(s), 1'(u));
                g  = gam_s[cv];
                ag = fp_add(alpha_k_s[s], g);
                alpha_nxt_s[ns] = fp_max(alpha_nxt_s[ns], ag);
                beta_nxt_s[s]   = fp_max(beta_nxt_s[s], fp_add(g, beta_q[ns]));
                pm = fp_add(ag, beta_q[ns]);
                for (int j = 0; j < NO; j++) begin
                    if (cv[j]) mx1_s[j] = fp_max(mx1_s[j], pm);
                    else mx0_s[j] = fp_max(mx0_s[j], pm);
                end
            end
        end
        for (int j = 0; j < NO; j++) begin
            llr_pk_s[j*32 +: 32] = fp_add(mx1_s[j], {~mx0_s[j][31], mx0_s[j][30:0]});
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_LOAD; else state_d = ST_IDLE;
            ST_LOAD: if (in_valid && cnt_q == LAST) state_d = ST_FWD; else state_d = ST_LOAD;
            ST_FWD:  if (cnt_q == LAST) state_d = ST_BWD; else state_d = ST_FWD;
            ST_BWD:  if (cnt_q == ZERO) state_d = ST_OUT; else state_d = ST_BWD;
            ST_OUT:  if (cnt_q == LAST) state_d = ST_IDLE; else state_d = ST_OUT;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: step 0 is taken straight from the datapath as the buffer write lands
    always_comb begin
        out_valid_d = (state_d == ST_OUT);
        llr_out_d   = {VW{1'b0}};
        if (state_q == ST_BWD && state_d == ST_OUT) llr_out_d = llr_pk_s;
        else if (state_q == ST_OUT && state_d == ST_OUT) llr_out_d = out_mem[cnt_q + 1'b1];
        else llr_out_d = {VW{1'b0}};
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            llr_out_q   <= {VW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            llr_out_q   <= llr_out_d;
        end
    end

    // Step counter and recursion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= ZERO;
            for (int s = 0; s < STATES; s++) begin
                alpha_q[s] <= 32'h0;
                beta_q[s]  <= 32'h0;
            end
        end else begin
            case (state_q)
                ST_IDLE: cnt_q <= in_valid ? CW'(1) : ZERO;
                ST_LOAD: begin
                    if (in_valid) cnt_q <= (cnt_q == LAST) ? ZERO : cnt_q + 1'b1;
                    for (int s = 0; s < STATES; s++) alpha_q[s] <= (s == 0) ? 32'h0 : NEG_INF;
                end
                ST_FWD: begin
                    cnt_q <= (cnt_q == LAST) ? LAST : cnt_q + 1'b1;
                    for (int s = 0; s < STATES; s++) begin
                        alpha_q[s] <= alpha_nxt_s[s];
                        beta_q[s]  <= 32'h0;
                    end
                end
                ST_BWD: begin
                    cnt_q <= (cnt_q == ZERO) ? ZERO : cnt_q - 1'b1;
                    for (int s = 0; s < STATES; s++) beta_q[s] <= beta_nxt_s[s];
                end
                ST_OUT:  cnt_q <= (cnt_q == LAST) ? ZERO : cnt_q + 1'b1;
                default: cnt_q <= ZERO;
            endcase
        end
    end

    // Frame, alpha and output buffers (data only, no reset needed)
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE || state_q == ST_LOAD) && in_valid) llr_mem[cnt_q] <= LLRVector;
        if (state_q == ST_FWD) begin
            for (int s = 0; s < STATES; s++) alpha_mem[cnt_q][s*32 +: 32] <= alpha_q[s];
        end
        if (state_q == ST_BWD) out_mem[cnt_q] <= llr_pk_s;
    end

    assign out_valid = out_valid_q;
    assign LLR_D     = llr_out_q;

endmodule

// File: tb/tb_stream_bcjr_max_product_core.sv
module tb_stream_bcjr_max_product_core;

    localparam int SYM = 17;
    localparam int NEG = -1000000;
    localparam int MAX_LAT = 4 * SYM + 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] LLRVector;
    logic        out_valid;
    logic [63:0] LLR_D;

    always #5 clk = ~clk;

    stream_bcjr_max_product_core dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .LLRVector (LLRVector),
        .out_valid (out_valid),
        .LLR_D     (LLR_D)
    );

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb [$];
    logic [63:0] cap [$];
    int          frm [SYM][2];
    int          cyc = 0;
    int          out_beats = 0;
    int          run_len = 0;
    int          last_in_cyc = 0;
    int          first_out_cyc = 0;
    bit          first_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Integer to float32 bits (exact for the small integers used here)
    function automatic logic [31:0] i2f(input int v);
        logic [31:0] r;
        int mag, p;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 30; i++) if (mag >= (1 << i)) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    function automatic int iadd(input int a, input int b);
        return (a == NEG || b == NEG) ? NEG : a + b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference max-log BCJR in exact integer arithmetic; pushes the expected beats
    task automatic push_expected();
        int al [SYM+1][4];
        int be [SYM+1][4];
        int s1, s0, a, c0, c1, ns, g, m, m1_0, m0_0, m1_1, m0_1;
        for (int s = 0; s < 4; s++) begin
            al[0][s]   = (s == 0) ? 0 : NEG;
            be[SYM][s] = 0;
        end
        for (int k = 0; k < SYM; k++) begin
            for (int s = 0; s < 4; s++) al[k+1][s] = NEG;
            for (int s = 0; s < 4; s++) for (int u = 0; u < 2; u++) begin
                s1 = (s >> 1) & 1; s0 = s & 1;
                a = u ^ s1 ^ s0; c0 = a ^ s0; c1 = a ^ s1 ^ s0; ns = a * 2 + s1;
                g = (c0 ? frm[k][0] : 0) + (c1 ? frm[k][1] : 0);
                al[k+1][ns] = imax(al[k+1][ns], iadd(al[k][s], g));
            end
        end
        for (int k = SYM - 1; k >= 0; k--) begin
            m1_0 = NEG; m0_0 = NEG; m1_1 = NEG; m0_1 = NEG;
            for (int s = 0; s < 4; s++) be[k][s] = NEG;
            for (int s = 0; s < 4; s++) for (int u = 0; u < 2; u++) begin
                s1 = (s >> 1) & 1; s0 = s & 1;
                a = u ^ s1 ^ s0; c0 = a ^ s0; c1 = a ^ s1 ^ s0; ns = a * 2 + s1;
                g = (c0 ? frm[k][0] : 0) + (c1 ? frm[k][1] : 0);
                be[k][s] = imax(be[k][s], g + be[k+1][ns]);
                m = iadd(iadd(al[k][s], g), be[k+1][ns]);
                if (c0) m1_0 = imax(m1_0, m); else m0_0 = imax(m0_0, m);
                if (c1) m1_1 = imax(m1_1, m); else m0_1 = imax(m0_1, m);
            end
            al[k][0] = m1_0 - m0_0;  // reuse as LLR scratch for step k
            al[k][1] = m1_1 - m0_1;
        end
        for (int k = 0; k < SYM; k++) sb.push_back({i2f(al[k][1]), i2f(al[k][0])});
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [63:0] exp_w;
        if (out_valid === 1'b1) begin
            out_beats++;
            run_len++;
            cap.push_back(LLR_D);
            if (!first_seen) begin first_seen = 1'b1; first_out_cyc = cyc; end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h expected=none", LLR_D);
            end else begin
                exp_w = sb.pop_front();
                if (LLR_D !== exp_w) begin
                    failures++;
                    $display("FAIL llr_word got=%h expected=%h", LLR_D, exp_w);
                end
            end
        end else begin
            checks++;
            if (LLR_D !== 64'h0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_output got valid=%b llr=%h expected valid=0 llr=0", out_valid, LLR_D);
            end
            if (run_len != 0) begin
                checks++;
                if (run_len != SYM) begin
                    failures++;
                    $display("FAIL out_valid_run got=%0d expected=%0d", run_len, SYM);
                end
                run_len = 0;
            end
        end
    end

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drive_beat(input int l0, input int l1);
        in_valid  = 1'b1;
        LLRVector = {i2f(l1), i2f(l0)};
        @(posedge clk); #1;
        last_in_cyc = cyc;
    endtask

    task automatic send_frame(input int gap_max, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            repeat ((gap_max > 0) ? $urandom_range(0, gap_max) : 0) idle_cycle();
            drive_beat(frm[k][0], frm[k][1]);
        end
        in_valid = 1'b0;
    endtask

    task automatic random_frame();
        for (int k = 0; k < SYM; k++) begin
            frm[k][0] = ($urandom_range(0, 1) == 1) ? 1 : -1;
            frm[k][1] = ($urandom_range(0, 1) == 1) ? 1 : -1;
        end
    endtask

    // Bounded wait until every expected beat has been consumed
    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; LLRVector = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || LLR_D !== 64'h0) begin
            failures++;
            $display("FAIL reset_state got valid=%b llr=%h expected valid=0 llr=0", out_valid, LLR_D);
        end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_zero();
        bit ok; int b0;
        for (int k = 0; k < SYM; k++) begin frm[k][0] = 0; frm[k][1] = 0; end
        b0 = out_beats; first_seen = 1'b0; cap.delete();
        push_expected();
        send_frame(0, SYM);
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zero_timeout got=pending expected=drained"); end
        checks++;
        if (out_beats - b0 != SYM) begin failures++; $display("FAIL zero_beats got=%0d expected=%0d", out_beats - b0, SYM); end
        for (int i = 0; i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== 64'h0) begin failures++; $display("FAIL zero_word got=%h expected=0", cap[i]); end
        end
        checks++;
        if (!first_seen || first_out_cyc - last_in_cyc > MAX_LAT) begin
            failures++; $display("FAIL zero_latency got=%0d expected<=%0d", first_out_cyc - last_in_cyc, MAX_LAT);
        end
    endtask

    task automatic test_all_neg();
        bit ok; int b0;
        for (int k = 0; k < SYM; k++) begin frm[k][0] = -1; frm[k][1] = -1; end
        b0 = out_beats; cap.delete();
        push_expected();
        send_frame(0, SYM);
        wait_drain(ok);
        checks++;
        if (!ok || out_beats - b0 != SYM) begin
            failures++; $display("FAIL neg_beats got=%0d expected=%0d", out_beats - b0, SYM);
        end
        for (int i = 0; i < cap.size(); i++) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (cap[i][j*32+31] !== 1'b1 || cap[i][j*32 +: 31] < 31'h3F80_0000) begin
                    failures++; $display("FAIL neg_sign_mag got=%h expected=<=-1.0", cap[i][j*32 +: 32]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok; int b0;
        for (int f = 0; f < 4; f++) begin
            random_frame();
            b0 = out_beats;
            push_expected();
            send_frame(0, SYM);
            wait_drain(ok);
            checks++;
            if (!ok || out_beats - b0 != SYM) begin
                failures++; $display("FAIL random_beats frame=%0d got=%0d expected=%0d", f, out_beats - b0, SYM);
            end
            repeat ($urandom_range(0, 3)) idle_cycle();
        end
    endtask

    task automatic test_gaps();
        bit ok;
        logic [63:0] first_run [$];
        random_frame();
        cap.delete();
        push_expected();
        send_frame(3, SYM);
        wait_drain(ok);
        first_run = cap;
        cap.delete();
        push_expected();
        send_frame(0, SYM);
        wait_drain(ok);
        checks++;
        if (!ok || first_run.size() != SYM || cap.size() != SYM) begin
            failures++; $display("FAIL gaps_beats got=%0d/%0d expected=%0d", first_run.size(), cap.size(), SYM);
        end else begin
            for (int i = 0; i < SYM; i++) begin
                checks++;
                if (first_run[i] !== cap[i]) begin
                    failures++; $display("FAIL gaps_vs_nogaps got=%h expected=%h", first_run[i], cap[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok; int b0;
        random_frame();
        send_frame(0, 8);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();
        random_frame();
        b0 = out_beats;
        push_expected();
        send_frame(0, SYM);
        wait_drain(ok);
        repeat (3) idle_cycle();
        checks++;
        if (!ok || out_beats - b0 != SYM) begin
            failures++; $display("FAIL abort_beats got=%0d expected=%0d", out_beats - b0, SYM);
        end
    endtask

    // in_valid stays high with junk through FWD/BWD/OUT; next frame starts right after the last output
    task automatic test_in_valid_held();
        bit ok; int b0;
        random_frame();
        b0 = out_beats;
        push_expected();
        send_frame(0, SYM);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) begin ok = 1'b1; break; end
            in_valid  = 1'b1;
            LLRVector = {$urandom, $urandom} & 64'h3FFF_FFFF_3FFF_FFFF;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin failures++; sb.delete(); $display("FAIL held_timeout got=pending expected=drained"); end
        random_frame();
        push_expected();
        send_frame(0, SYM);
        wait_drain(ok);
        repeat (3) idle_cycle();
        checks++;
        if (!ok || out_beats - b0 != 2 * SYM) begin
            failures++; $display("FAIL back_to_back_beats got=%0d expected=%0d", out_beats - b0, 2 * SYM);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; LLRVector = 64'h0;
        test_reset();
        test_zero();
        test_all_neg();
        test_random();
        test_gaps();
        test_reset_midframe();
        test_in_valid_held();
        repeat (3) idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
